// File: rtl/cpu_mem_pkg.sv
// Shared types and helpers for the core memory responder.
// Size codes, MMIO offsets and byte-lane alignment.
package cpu_mem_pkg;

    localparam logic [3:0] BE_BYTE = 4'h1;
    localparam logic [3:0] BE_HALF = 4'h3;
    localparam logic [3:0] BE_WORD = 4'hf;

    localparam logic [3:0] MMIO_LEDS     = 4'h0;
    localparam logic [3:0] MMIO_CYCLE    = 4'h4;
    localparam logic [3:0] MMIO_HALT     = 4'h8;
    localparam logic [3:0] MMIO_MISALIGN = 4'hc;

    typedef struct packed {
        logic [3:0]  mask;
        logic [31:0] data;
        logic        misaligned;
    } lane_t;

    function automatic logic lane_mis(
        input logic [3:0] be,
        input logic [1:0] off
    );
        logic [6:0] wide;
        wide = {3'b000, be} << off;
        return |wide[6:4];
    endfunction

    function automatic lane_t lane_align(
        input logic [3:0]  be,
        input logic [1:0]  off,
        input logic [31:0] wdata
    );
        lane_t      r;
        logic [6:0] wide;
        wide         = {3'b000, be} << off;
        r.mask       = wide[3:0];
        r.data       = wdata << {off, 3'b000};
        r.misaligned = lane_mis(be, off);
        return r;
    endfunction

    function automatic logic [31:0] size_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/cpu_mem_responder_if.sv
// Core-side bus bundle: instruction port and load/store port.
// master = core, slave = memory responder.
interface cpu_mem_responder_if #(
    parameter int IW = 32
);
    logic [IW-1:0] i_pc_addr;
    logic          i_pc_rd;
    logic [3:0]    i_pc_byte_en;
    logic [IW-1:0] o_pc_rddata;

    logic [IW-1:0] i_ldst_addr;
    logic          i_ldst_rd;
    logic          i_ldst_wr;
    logic [IW-1:0] i_ldst_wrdata;
    logic [3:0]    i_ldst_byte_en;
    logic [IW-1:0] o_ldst_rddata;

    modport master (
        output i_pc_addr, i_pc_rd, i_pc_byte_en,
        output i_ldst_addr, i_ldst_rd, i_ldst_wr,
        output i_ldst_wrdata, i_ldst_byte_en,
        input  o_pc_rddata, o_ldst_rddata
    );

    modport slave (
        input  i_pc_addr, i_pc_rd, i_pc_byte_en,
        input  i_ldst_addr, i_ldst_rd, i_ldst_wr,
        input  i_ldst_wrdata, i_ldst_byte_en,
        output o_pc_rddata, o_ldst_rddata
    );

endinterface

// File: rtl/mem_byte_ram.sv
// Dual-port word RAM: read-only port A, read/write port B.
// Per-byte write enables, registered read data.
module mem_byte_ram #(
    parameter int DEPTH     = 4096,
    parameter int AW        = $clog2(DEPTH),
    parameter     INIT_FILE = ""
) (
    input  logic          clk,
    input  logic          en_a,
    input  logic [AW-1:0] addr_a,
    output logic [31:0]   q_a,
    input  logic          en_b,
    input  logic [3:0]    we_b,
    input  logic [AW-1:0] addr_b,
    input  logic [31:0]   wdata_b,
    output logic [31:0]   q_b
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en_a) q_a <= mem[addr_a];
        if (en_b) q_b <= mem[addr_b];
        for (int i = 0; i < 4; i++) begin
            if (we_b[i]) mem[addr_b][8*i +: 8] <= wdata_b[8*i +: 8];
        end
    end

endmodule

// File: rtl/cpu_mem_responder.sv
// Memory responder for the multicycle RV32 core: shared RAM,
// alignment checks, MMIO window (LEDs, cycle, halt, misalign count).
module cpu_mem_responder
    import cpu_mem_pkg::*;
#(
    parameter int          IW        = 32,
    parameter int          DEPTH     = 4096,
    parameter logic [31:0] MMIO_BASE = 32'h0000_F000,
    parameter              INIT_FILE = ""
) (
    input  logic                  clk,
    input  logic                  reset,
    cpu_mem_responder_if.slave    bus,
    output logic [IW-1:0]         o_leds,
    output logic                  o_halt,
    output logic [15:0]           o_misalign_cnt
);

    localparam int AW = $clog2(DEPTH);

    lane_t       ls_ln;
    logic        pc_bad, pc_mmio, pc_go;
    logic        ls_bad, ls_mmio, ls_load, ls_go;
    logic        ls_acc, mmio_wr;
    logic [3:0]  ram_we;
    logic [31:0] ram_qa, ram_qb;

    assign pc_bad  = lane_mis(bus.i_pc_byte_en, bus.i_pc_addr[1:0]);
    assign pc_mmio = bus.i_pc_addr[IW-1:4] == MMIO_BASE[IW-1:4];
    assign pc_go   = bus.i_pc_rd && !reset;

    assign ls_ln   = lane_align(bus.i_ldst_byte_en,
                                bus.i_ldst_addr[1:0],
                                bus.i_ldst_wrdata);
    assign ls_mmio = bus.i_ldst_addr[IW-1:4] == MMIO_BASE[IW-1:4];
    // MMIO registers are word-only; narrower accesses count as misaligned.
    assign ls_bad  = ls_ln.misaligned ||
                     (ls_mmio && bus.i_ldst_byte_en != BE_WORD);
    assign ls_load = bus.i_ldst_rd && !bus.i_ldst_wr;
    assign ls_go   = ls_load && !reset;
    assign ls_acc  = bus.i_ldst_rd || bus.i_ldst_wr;
    assign mmio_wr = bus.i_ldst_wr && ls_mmio && !ls_bad && !reset;

    assign ram_we = (bus.i_ldst_wr && !ls_bad && !ls_mmio && !reset)
                  ? ls_ln.mask : 4'b0000;

    mem_byte_ram #(
        .DEPTH     (DEPTH),
        .AW        (AW),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk     (clk),
        .en_a    (pc_go && !pc_bad && !pc_mmio),
        .addr_a  (bus.i_pc_addr[AW+1:2]),
        .q_a     (ram_qa),
        .en_b    (ls_go && !ls_bad && !ls_mmio),
        .we_b    (ram_we),
        .addr_b  (bus.i_ldst_addr[AW+1:2]),
        .wdata_b (ls_ln.data),
        .q_b     (ram_qb)
    );

    logic [IW-1:0] cycle;
    logic [IW-1:0] mmio_rd, mmio_q;
    logic          sel_leds, sel_cycle, sel_halt, sel_mis;

    assign sel_leds  = bus.i_ldst_addr[3:2] == MMIO_LEDS[3:2];
    assign sel_cycle = bus.i_ldst_addr[3:2] == MMIO_CYCLE[3:2];
    assign sel_halt  = bus.i_ldst_addr[3:2] == MMIO_HALT[3:2];
    assign sel_mis   = bus.i_ldst_addr[3:2] == MMIO_MISALIGN[3:2];

    always_comb begin
        mmio_rd = '0;
        unique case (1'b1)
            sel_leds:  mmio_rd = o_leds;
            sel_cycle: mmio_rd = cycle;
            sel_halt:  mmio_rd = {{(IW-1){1'b0}}, o_halt};
            sel_mis:   mmio_rd = {{(IW-16){1'b0}}, o_misalign_cnt};
            default:   mmio_rd = '0;
        endcase
    end

    logic [1:0]  mis_inc;
    logic [16:0] mis_sum;

    assign mis_inc = {1'b0, bus.i_pc_rd && pc_bad}
                   + {1'b0, ls_acc && ls_bad};
    assign mis_sum = {1'b0, o_misalign_cnt} + {15'b0, mis_inc};

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle          <= '0;
            o_leds         <= '0;
            o_halt         <= 1'b0;
            o_misalign_cnt <= '0;
        end else begin
            cycle          <= cycle + 1'b1;
            o_misalign_cnt <= mis_sum[16] ? 16'hffff : mis_sum[15:0];
            if (mmio_wr && sel_leds) o_leds <= bus.i_ldst_wrdata;
            if (mmio_wr && sel_halt) o_halt <= 1'b1;
        end
    end

    logic       pc_zero, ls_zero, ls_sel_mmio;
    logic [1:0] pc_off, ls_off;
    logic [3:0] pc_be, ls_be;

    // Read metadata is latched with the access; RAM data is post-aligned.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_zero     <= 1'b1;
            pc_off      <= '0;
            pc_be       <= '0;
            ls_zero     <= 1'b1;
            ls_sel_mmio <= 1'b0;
            ls_off      <= '0;
            ls_be       <= '0;
            mmio_q      <= '0;
        end else begin
            if (bus.i_pc_rd) begin
                pc_zero <= pc_bad || pc_mmio;
                pc_off  <= bus.i_pc_addr[1:0];
                pc_be   <= bus.i_pc_byte_en;
            end
            if (ls_load) begin
                ls_zero     <= ls_bad;
                ls_sel_mmio <= ls_mmio;
                ls_off      <= bus.i_ldst_addr[1:0];
                ls_be       <= bus.i_ldst_byte_en;
                mmio_q      <= mmio_rd;
            end
        end
    end

    logic [31:0] pc_word, ls_word;

    assign pc_word = (ram_qa >> {pc_off, 3'b000}) & size_mask(pc_be);
    assign ls_word = (ram_qb >> {ls_off, 3'b000}) & size_mask(ls_be);

    assign bus.o_pc_rddata   = pc_zero ? '0 : pc_word;
    assign bus.o_ldst_rddata = ls_zero     ? '0
                             : ls_sel_mmio ? mmio_q
                             : ls_word;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Scoreboard bench for cpu_mem_responder: directed vectors push
// expected read data; a negedge monitor pops and compares.
module tb_cpu_mem_responder;
    import cpu_mem_pkg::*;

    localparam int DEPTH = 4096;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    cpu_mem_responder_if #(.IW(32)) bus ();
    logic [31:0] leds;
    logic        halt;
    logic [15:0] mcnt;

    cpu_mem_responder #(
        .IW        (32),
        .DEPTH     (DEPTH),
        .MMIO_BASE (32'h0000_F000),
        .INIT_FILE ("")
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus),
        .o_leds         (leds),
        .o_halt         (halt),
        .o_misalign_cnt (mcnt)
    );

    int          checks = 0;
    int          passes = 0;
    logic [31:0] pc_q[$];
    logic [31:0] ls_q[$];
    logic        pc_fired = 1'b0;
    logic        ls_fired = 1'b0;
    logic [31:0] tb_cyc = '0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(posedge clk) begin
        pc_fired <= bus.i_pc_rd && !reset;
        ls_fired <= bus.i_ldst_rd && !bus.i_ldst_wr && !reset;
        tb_cyc   <= reset ? 32'd0 : tb_cyc + 32'd1;
    end

    always @(negedge clk) begin
        if (pc_fired) begin
            if (pc_q.size() == 0) check("pc_unexpected", 32'd1, 32'd0);
            else check("pc_rddata", bus.o_pc_rddata, pc_q.pop_front());
        end
        if (ls_fired) begin
            if (ls_q.size() == 0) check("ls_unexpected", 32'd1, 32'd0);
            else check("ls_rddata", bus.o_ldst_rddata, ls_q.pop_front());
        end
    end

    task automatic clear();
        bus.i_pc_rd    = 1'b0;
        bus.i_ldst_rd  = 1'b0;
        bus.i_ldst_wr  = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        clear();
    endtask

    task automatic ls_set(input logic [31:0] a, input logic rd,
                          input logic wr, input logic [31:0] d,
                          input logic [3:0] be);
        bus.i_ldst_addr    = a;
        bus.i_ldst_rd      = rd;
        bus.i_ldst_wr      = wr;
        bus.i_ldst_wrdata  = d;
        bus.i_ldst_byte_en = be;
    endtask

    task automatic pc_set(input logic [31:0] a, input logic [3:0] be);
        bus.i_pc_addr    = a;
        bus.i_pc_rd      = 1'b1;
        bus.i_pc_byte_en = be;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be);
        ls_set(a, 1'b0, 1'b1, d, be);
        tick();
    endtask

    task automatic load(input logic [31:0] a, input logic [3:0] be,
                        input logic [31:0] exp);
        ls_q.push_back(exp);
        ls_set(a, 1'b1, 1'b0, '0, be);
        tick();
    endtask

    task automatic pc_read(input logic [31:0] a, input logic [3:0] be,
                           input logic [31:0] exp);
        pc_q.push_back(exp);
        pc_set(a, be);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] c1, c2;
        bus.i_pc_addr = '0;
        bus.i_pc_byte_en = BE_WORD;
        ls_set('0, 1'b0, 1'b0, '0, BE_WORD);
        clear();
        repeat (3) @(posedge clk);
        #1;
        check("rst_leds", leds, 32'd0);
        check("rst_halt", {31'd0, halt}, 32'd0);
        check("rst_mcnt", {16'd0, mcnt}, 32'd0);
        check("rst_pc_rd", bus.o_pc_rddata, 32'd0);
        check("rst_ls_rd", bus.o_ldst_rddata, 32'd0);
        reset = 1'b0;

        store(32'h10, 32'hdeadbeef, BE_WORD);
        load(32'h10, BE_WORD, 32'hdeadbeef);
        load(32'h13, BE_BYTE, 32'h0000_00de);
        load(32'h12, BE_HALF, 32'h0000_dead);

        store(32'h20, 32'h1122_3344, BE_WORD);
        pc_q.push_back(32'h1122_3344);
        pc_set(32'h20, BE_WORD);
        ls_set(32'h21, 1'b0, 1'b1, 32'h0000_00aa, BE_BYTE);
        tick();
        load(32'h20, BE_WORD, 32'h1122_aa44);

        store(32'h30, 32'h1234_5678, BE_WORD);
        store(32'h31, 32'hcafe_f00d, BE_WORD);
        check("mcnt_store", {16'd0, mcnt}, 32'd1);
        load(32'h30, BE_WORD, 32'h1234_5678);

        pc_q.push_back(32'd0);
        ls_q.push_back(32'd0);
        pc_set(32'h15, BE_WORD);
        ls_set(32'h13, 1'b1, 1'b0, '0, BE_HALF);
        tick();
        check("mcnt_dual", {16'd0, mcnt}, 32'd3);

        store(32'hf000, 32'h5a, BE_WORD);
        check("leds_wr", leds, 32'h5a);
        load(32'hf000, BE_WORD, 32'h5a);

        load(32'hf004, BE_WORD, tb_cyc);
        c1 = bus.o_ldst_rddata;
        repeat (9) tick();
        load(32'hf004, BE_WORD, tb_cyc);
        c2 = bus.o_ldst_rddata;
        check("cycle_diff", c2 - c1, 32'd10);

        store(32'hf008, 32'd0, BE_WORD);
        check("halt_set", {31'd0, halt}, 32'd1);
        repeat (3) tick();
        check("halt_sticky", {31'd0, halt}, 32'd1);
        load(32'hf008, BE_WORD, 32'd1);
        load(32'hf00c, BE_WORD, 32'd3);

        store(32'hf000, 32'hff, BE_BYTE);
        check("mmio_byte_cnt", {16'd0, mcnt}, 32'd4);
        check("mmio_byte_leds", leds, 32'h5a);

        load(32'h10 + 4 * DEPTH, BE_WORD, 32'hdeadbeef);
        pc_read(32'h10, BE_WORD, 32'hdeadbeef);
        pc_read(32'hf000, BE_WORD, 32'd0);

        ls_set(32'h40, 1'b1, 1'b1, 32'h77, BE_WORD);
        tick();
        check("rdwr_hold", bus.o_ldst_rddata, 32'hdeadbeef);
        load(32'h40, BE_WORD, 32'h77);

        reset = 1'b1;
        ls_set(32'h10, 1'b0, 1'b1, 32'hffff_ffff, BE_WORD);
        tick();
        check("rst2_halt", {31'd0, halt}, 32'd0);
        check("rst2_leds", leds, 32'd0);
        check("rst2_mcnt", {16'd0, mcnt}, 32'd0);
        check("rst2_pc_rd", bus.o_pc_rddata, 32'd0);
        check("rst2_ls_rd", bus.o_ldst_rddata, 32'd0);
        reset = 1'b0;
        load(32'hf004, BE_WORD, 32'd0);
        load(32'h10, BE_WORD, 32'hdeadbeef);

        repeat (2) tick();
        check("queues_drained", pc_q.size() + ls_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
